// File: rtl/tt_capture_pkg.sv
// Shared types and helpers for the truth-table response capture block.
package tt_capture_pkg;

    localparam int TT_N_IN     = 4;
    localparam int TT_MAX_N_IN = 8;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VEC,
        SETTLE,
        SAMPLE,
        DONE
    } tt_state_e;

    // Golden tables are widened to the largest supported size before lookup.
    function automatic logic expected_bit(
        input logic [2**TT_MAX_N_IN-1:0] golden,
        input logic [TT_MAX_N_IN-1:0]    idx
    );
        return golden[idx];
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Settle-phase down-counter: loads a start value, counts to zero, flags zero.
module tt_settle_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/tt_response_capture.sv
// Captures the observed truth table of a combinational DUT during an exhaustive sweep.
// Optional X/Z checking on s_in is enabled by defining TT_XCHECK_EN (adds err_x).
module tt_response_capture
    import tt_capture_pkg::*;
#(
    parameter int                  N_IN          = TT_N_IN,
    parameter logic [2**N_IN-1:0]  EXPECTED      = '0,
    parameter int                  SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                vec_valid,
    input  logic [N_IN-1:0]     vec_in,
    output logic                vec_ready,
    input  logic                sweep_end,
    input  logic                s_in,
    output logic [2**N_IN-1:0]  table_out,
    output logic [2**N_IN-1:0]  cov_out,
    output logic [N_IN:0]       mismatch_cnt,
    output logic                err_dup,
`ifdef TT_XCHECK_EN
    output logic                err_x,
`endif
    output logic                done,
    output logic                pass
);

    localparam int NE    = 2**N_IN;
    localparam int CNT_W = 4;

    tt_state_e          state, state_nxt;
    logic [N_IN-1:0]    vec_q;
    logic               end_pend;
    logic               accept, sample_en, clr, tmr_load, tmr_zero;
    logic               exp_bit, s_bit, s_bad, first_hit, cov_full_nxt;
    logic [NE-1:0]      vec_onehot;
`ifdef TT_XCHECK_EN
    logic               s_x;
`endif

    tt_settle_timer #(
        .CNT_W (CNT_W)
    ) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (CNT_W'(SETTLE_CYCLES - 1)),
        .dec      (state == SETTLE),
        .zero     (tmr_zero)
    );

    assign exp_bit    = expected_bit((2**TT_MAX_N_IN)'(EXPECTED), TT_MAX_N_IN'(vec_q));
    assign first_hit  = !cov_out[vec_q];
    assign vec_onehot = {{(NE-1){1'b0}}, 1'b1} << vec_q;
    assign cov_full_nxt = &(cov_out | vec_onehot);

`ifdef TT_XCHECK_EN
    // An unknown response is recorded as 0 and always counts against the sweep.
    assign s_x   = $isunknown(s_in);
    assign s_bit = s_x ? 1'b0 : s_in;
    assign s_bad = s_x || (s_in != exp_bit);
`else
    assign s_bit = s_in;
    assign s_bad = (s_in != exp_bit);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A start pulse in any state clears the results and (re)opens a sweep.
    always_comb begin
        state_nxt = state;
        vec_ready = 1'b0;
        accept    = 1'b0;
        sample_en = 1'b0;
        clr       = 1'b0;
        tmr_load  = 1'b0;
        if (start) begin
            clr       = 1'b1;
            state_nxt = WAIT_VEC;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = IDLE;
                end
                WAIT_VEC: begin
                    vec_ready = 1'b1;
                    if (vec_valid) begin
                        accept    = 1'b1;
                        tmr_load  = 1'b1;
                        state_nxt = SETTLE;
                    end else if (sweep_end) begin
                        state_nxt = DONE;
                    end
                end
                SETTLE: begin
                    if (tmr_zero) begin
                        state_nxt = SAMPLE;
                    end
                end
                SAMPLE: begin
                    sample_en = 1'b1;
                    state_nxt = (cov_full_nxt || end_pend) ? DONE : WAIT_VEC;
                end
                DONE: begin
                    state_nxt = DONE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            vec_q <= vec_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            table_out    <= '0;
            cov_out      <= '0;
            mismatch_cnt <= '0;
            err_dup      <= 1'b0;
            end_pend     <= 1'b0;
`ifdef TT_XCHECK_EN
            err_x        <= 1'b0;
`endif
        end else if (clr) begin
            table_out    <= '0;
            cov_out      <= '0;
            mismatch_cnt <= '0;
            err_dup      <= 1'b0;
            end_pend     <= 1'b0;
`ifdef TT_XCHECK_EN
            err_x        <= 1'b0;
`endif
        end else begin
            if (accept && sweep_end) begin
                end_pend <= 1'b1;
            end
            if (sample_en) begin
                table_out[vec_q] <= s_bit;
                cov_out[vec_q]   <= 1'b1;
                // A repeated vector only flags the duplicate; its mismatch was already counted.
                if (!first_hit) begin
                    err_dup <= 1'b1;
                end else if (s_bad && (mismatch_cnt != '1)) begin
                    mismatch_cnt <= mismatch_cnt + 1'b1;
                end
`ifdef TT_XCHECK_EN
                if (s_x) begin
                    err_x <= 1'b1;
                end
`endif
            end
        end
    end

    assign done = (state == DONE);
`ifdef TT_XCHECK_EN
    assign pass = done && (&cov_out) && (mismatch_cnt == '0) && !err_dup && !err_x;
`else
    assign pass = done && (&cov_out) && (mismatch_cnt == '0) && !err_dup;
`endif

endmodule

// File: tb/tb_tt_response_capture.sv
// Bench for tt_response_capture: directed scenarios plus randomized sweeps against a table model.
module tb_tt_response_capture;

    localparam int          N_IN = 4;
    localparam logic [15:0] EXP  = 16'h8000;
    localparam int          SC   = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        vec_valid = 1'b0;
    logic        sweep_end = 1'b0;
    logic        s_in = 1'b0;
    logic [3:0]  vec_in = 4'd0;
    logic        vec_ready, err_dup, done, pass;
    logic [15:0] table_out, cov_out;
    logic [4:0]  mismatch_cnt;
`ifdef TT_XCHECK_EN
    logic        err_x;
`endif

    tt_response_capture #(
        .N_IN          (N_IN),
        .EXPECTED      (EXP),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .vec_valid    (vec_valid),
        .vec_in       (vec_in),
        .vec_ready    (vec_ready),
        .sweep_end    (sweep_end),
        .s_in         (s_in),
        .table_out    (table_out),
        .cov_out      (cov_out),
        .mismatch_cnt (mismatch_cnt),
        .err_dup      (err_dup),
`ifdef TT_XCHECK_EN
        .err_x        (err_x),
`endif
        .done         (done),
        .pass         (pass)
    );

    always #5 clk = ~clk;

    // Behavioural model: what the sweep has recorded so far.
    logic [15:0] gold = EXP;
    logic [15:0] m_tab = '0;
    logic [15:0] m_cov = '0;
    int          m_mis = 0;
    bit          m_dup = 1'b0;
    bit          m_done = 1'b0;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: no response within cycle budget", name);
    endtask

    function automatic void model_clear();
        m_tab  = '0;
        m_cov  = '0;
        m_mis  = 0;
        m_dup  = 1'b0;
        m_done = 1'b0;
    endfunction

    function automatic void model_sample(input logic [3:0] v, input logic s);
        if (m_cov[v]) m_dup = 1'b1;
        else if (s != gold[v] && m_mis < 31) m_mis++;
        m_tab[v] = s;
        m_cov[v] = 1'b1;
    endfunction

    function automatic bit m_pass();
        return m_done && (m_cov == 16'hFFFF) && (m_mis == 0) && !m_dup;
    endfunction

    // Results are compared whenever the block is waiting for a vector or holding its report.
    always @(negedge clk) begin
        if (rst_n && (vec_ready || done)) begin
            chk("table", 32'(table_out), 32'(m_tab));
            chk("cov", 32'(cov_out), 32'(m_cov));
            chk("mismatch_cnt", 32'(mismatch_cnt), 32'(m_mis));
            chk("err_dup", 32'(err_dup), 32'(m_dup));
            chk("done", 32'(done), 32'(m_done));
            chk("pass", 32'(pass), 32'(m_pass()));
        end
    end

    task automatic wait_ready(output bit ok);
        int n = 0;
        ok = 1'b1;
        @(negedge clk);
        while (!vec_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!vec_ready) begin
            timeout("wait_ready");
            ok = 1'b0;
        end
    endtask

    task automatic send(input logic [3:0] v, input logic s, input bit last);
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        vec_in    = v;
        vec_valid = 1'b1;
        s_in      = s;
        sweep_end = last;
        @(posedge clk);
        #1;
        vec_valid = 1'b0;
        sweep_end = 1'b0;
        model_sample(v, s);
        if (m_cov == 16'hFFFF || last) m_done = 1'b1;
    endtask

    task automatic end_sweep();
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        sweep_end = 1'b1;
        @(posedge clk);
        #1;
        sweep_end = 1'b0;
        m_done = 1'b1;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        model_clear();
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        @(negedge clk);
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!done) timeout(name);
    endtask

    // Accepts v with s_old applied, then switches s_in to s_new k edges after the accept edge.
    task automatic settle_probe(input logic [3:0] v, input logic s_old, input logic s_new,
                                input int k, input logic captured);
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        vec_in    = v;
        vec_valid = 1'b1;
        s_in      = s_old;
        @(posedge clk);
        #1;
        vec_valid = 1'b0;
        model_sample(v, captured);
        repeat (k) @(posedge clk);
        #1;
        s_in = s_new;
    endtask

    logic [3:0] q[$];
    logic [3:0] perm[16];

    initial begin : main
        bit ok;
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_vec_ready", 32'(vec_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_table", 32'(table_out), 32'd0);
        chk("rst_cov", 32'(cov_out), 32'd0);
        chk("rst_mis", 32'(mismatch_cnt), 32'd0);
        chk("rst_dup", 32'(err_dup), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_vec_ready", 32'(vec_ready), 32'd0);

        // Full AND4 sweep
        do_start();
        for (int v = 0; v < 16; v++) send(4'(v), gold[v], 1'b0);
        wait_done("full_done");
        chk("full_done", 32'(done), 32'd1);
        chk("full_pass", 32'(pass), 32'd1);
        chk("full_table", 32'(table_out), 32'h8000);
        chk("full_cov", 32'(cov_out), 32'hFFFF);
        chk("full_mis", 32'(mismatch_cnt), 32'd0);

        // Incomplete sweep, vectors 3 and 5 missing
        do_start();
        for (int v = 0; v < 16; v++) if (v != 3 && v != 5) send(4'(v), gold[v], 1'b0);
        end_sweep();
        wait_done("inc_done");
        chk("inc_done", 32'(done), 32'd1);
        chk("inc_pass", 32'(pass), 32'd0);
        chk("inc_cov", 32'(cov_out), 32'hFFD7);

        // Single mismatch on vector 6
        do_start();
        for (int v = 0; v < 16; v++) send(4'(v), (v == 6) ? 1'b1 : gold[v], 1'b0);
        wait_done("mis_done");
        chk("mis_cnt", 32'(mismatch_cnt), 32'd1);
        chk("mis_table6", 32'(table_out[6]), 32'd1);
        chk("mis_pass", 32'(pass), 32'd0);

        // Vector 1 offered twice; the repeat carries a wrong response
        do_start();
        send(4'd0, gold[0], 1'b0);
        send(4'd1, gold[1], 1'b0);
        send(4'd1, 1'b1, 1'b0);
        for (int v = 2; v < 16; v++) send(4'(v), gold[v], 1'b0);
        wait_done("dup_done");
        chk("dup_flag", 32'(err_dup), 32'd1);
        chk("dup_mis", 32'(mismatch_cnt), 32'd0);
        chk("dup_pass", 32'(pass), 32'd0);

        // Settle timing: accept-to-sample is SC+1 cycles
        do_start();
        send(4'd9, 1'b0, 1'b0);
        n = 0;
        @(negedge clk);
        while (!vec_ready && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("settle_latency", 32'(n), 32'(SC + 1));
        settle_probe(4'd0, 1'b1, 1'b0, 3, 1'b0);
        wait_ready(ok);
        chk("settle_k3_new", 32'(table_out[0]), 32'd0);
        chk("settle_k3_cov", 32'(cov_out[0]), 32'd1);
        settle_probe(4'd1, 1'b0, 1'b1, 5, 1'b0);
        wait_ready(ok);
        chk("settle_k5_old", 32'(table_out[1]), 32'd0);
        settle_probe(4'd15, 1'b0, 1'b1, 3, 1'b1);
        wait_ready(ok);
        chk("settle_k3_rise", 32'(table_out[15]), 32'd1);
        end_sweep();
        wait_done("settle_done");

        // Abort with start during SETTLE
        do_start();
        for (int v = 0; v < 5; v++) send(4'(v), gold[v], 1'b0);
        send(4'd5, 1'b1, 1'b0);
        do_start();
        chk("abort_cov", 32'(cov_out), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        for (int v = 15; v >= 0; v--) send(4'(v), gold[v], 1'b0);
        wait_done("abort_resweep");
        chk("abort_resweep_pass", 32'(pass), 32'd1);

        // Asynchronous reset while in SETTLE
        do_start();
        send(4'd0, 1'b1, 1'b0);
        send(4'd15, 1'b1, 1'b0);
        send(4'd7, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("arst_vec_ready", 32'(vec_ready), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_table", 32'(table_out), 32'd0);
        chk("arst_mis", 32'(mismatch_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_start();
        for (int v = 0; v < 16; v++) send(4'(v), gold[v], 1'b0);
        wait_done("arst_resweep");
        chk("arst_resweep_pass", 32'(pass), 32'd1);

        // Randomized sweeps: shuffled order, random responses, duplicates, early ends, gaps
        for (int r = 0; r < 30; r++) begin
            int len, j, p;
            bit early, joint;
            do_start();
            for (int i = 0; i < 16; i++) perm[i] = 4'(i);
            for (int i = 15; i > 0; i--) begin
                logic [3:0] t;
                j = $urandom_range(0, i);
                t = perm[i];
                perm[i] = perm[j];
                perm[j] = t;
            end
            early = ($urandom_range(0, 2) == 0);
            len = early ? $urandom_range(1, 15) : 16;
            q.delete();
            for (int i = 0; i < len; i++) q.push_back(perm[i]);
            if (len >= 2 && $urandom_range(0, 2) == 0) begin
                j = $urandom_range(0, len - 2);
                p = $urandom_range(j + 1, len - 1);
                q.insert(p, q[j]);
            end
            joint = early && ($urandom_range(0, 1) == 1);
            for (int i = 0; i < q.size(); i++) begin
                logic s;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                s = gold[q[i]] ^ ($urandom_range(0, 5) == 0);
                send(q[i], s, joint && (i == q.size() - 1));
            end
            if (early && !joint) end_sweep();
            wait_done("rand_done");
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d tests run", tests);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/tt_response_capture.md
Name: tt_response_capture

Overview:
- Receiving end of the exhaustive-stimulus flow used to exercise 4-input combinational circuits.
- A stimulus generator offers input vectors over a valid/ready handshake. This block waits a programmable settle time, samples the DUT output and builds the observed truth table bit by bit.
- When every vector has been seen, or when the generator ends the sweep early, it reports the table, coverage, mismatch count and pass/fail against an expected table.

Parameters:
- N_IN, 4, number of DUT inputs; truth table has 2**N_IN entries.
- EXPECTED, 16'h0000 (width 2**N_IN), golden truth table; bit i is the expected output for input vector i.
- SETTLE_CYCLES, 2, clock cycles between vector acceptance and output sampling; legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; clears table, coverage and flags, then begins a sweep.
- vec_valid  in  1  generator has a vector on vec_in.
- vec_in  in  N_IN  input vector currently applied to the DUT.
- vec_ready  out  1  block can accept a vector this cycle.
- sweep_end  in  1  generator has no more vectors (early termination).
- s_in  in  1  DUT output under observation.
- table_out  out  2**N_IN  observed truth table.
- cov_out  out  2**N_IN  bit i set when vector i has been sampled.
- mismatch_cnt  out  N_IN+1  count of sampled entries differing from EXPECTED.
- err_dup  out  1  sticky; a vector was offered twice in one sweep.
- done  out  1  level; sweep finished, results stable.
- pass  out  1  valid while done=1.

Behaviour:
- Reset: every output is 0, FSM state is IDLE.
- FSM states are IDLE, WAIT_VEC, SETTLE, SAMPLE and DONE.
- IDLE: vec_ready=0. On start, clear table_out, cov_out, mismatch_cnt, err_dup and done, then go to WAIT_VEC.
- WAIT_VEC: vec_ready=1.
  - vec_valid=1 latches vec_in into vec_q, loads the settle counter with SETTLE_CYCLES-1 and moves to SETTLE.
  - sweep_end=1 with no vec_valid moves to DONE.
  - If sweep_end and vec_valid are high together, accept the vector; the sweep ends after it is sampled.
- SETTLE: vec_ready=0; decrement the counter. At 0, move to SAMPLE.
- Timing: the total delay from the accept edge to the sample edge is exactly SETTLE_CYCLES+1 cycles.
- SAMPLE:
  - table_out[vec_q] <= s_in; cov_out[vec_q] <= 1.
  - If s_in != EXPECTED[vec_q], increment mismatch_cnt; the counter saturates at all-ones.
  - If cov_out[vec_q] was already 1, set err_dup. The new sample overwrites the table entry, but mismatch_cnt is not incremented a second time for that vector.
  - Next state: DONE if coverage is now complete or a sweep_end is pending; otherwise WAIT_VEC.
- DONE: done=1. pass = (cov_out all ones) AND (mismatch_cnt==0) AND !err_dup.
  - An incomplete sweep always gives pass=0.
  - Outputs hold until the next start.
- start received in any state other than IDLE or DONE aborts the current sweep. Everything is cleared and the FSM returns to WAIT_VEC on the next cycle.
- Vectors may arrive in any order.
- rst_n asserted mid-sweep returns the FSM to IDLE immediately, asynchronously, with all outputs 0.
- vec_valid outside WAIT_VEC is ignored, and vec_in is not re-sampled in that case.

Optional Feature:
- Macro: TT_XCHECK_EN.
- Defined: in SAMPLE, an X or Z on s_in is counted as a mismatch, sets a sticky err_x output (1 bit, reset 0, cleared by start) and forces pass=0. The table bit is written as 0.
- Undefined: no err_x port; s_in is sampled as is.

Decomposition:
- tt_capture_pkg holds:
  - the state enum tt_state_e (IDLE, WAIT_VEC, SETTLE, SAMPLE, DONE);
  - the default N_IN localparam;
  - a function for expected-bit lookup.
- One natural sub-module, tt_settle_timer: load/decrement counter with a zero flag, used for the SETTLE phase.

Test Plan:
- Full sweep: send all 16 vectors 0..15 in order with s_in matching EXPECTED=16'h8000 (AND4). Expect done=1, pass=1, table_out=16'h8000, cov_out=16'hFFFF, mismatch_cnt=0.
- Incomplete sweep: send 14 vectors skipping 4'b0011 and 4'b0101, then pulse sweep_end. Expect done=1, pass=0, cov_out=16'hFFD7.
- Single mismatch: full sweep with s_in forced to 1 on vector 4'b0110. Expect mismatch_cnt=1, table_out[6]=1, pass=0.
- Duplicate vector: offer vector 4'b0001 twice within an otherwise complete sweep. Expect err_dup=1, pass=0, mismatch_cnt unchanged by the repeat.
- Settle timing, SETTLE_CYCLES=3: s_in changes 3 cycles after accept. Expect the new value captured. With a change 5 cycles after accept, expect the old value captured.
- Async reset: assert rst_n=0 while in SETTLE. Expect immediate vec_ready=0, done=0, table_out=0. After release and start, the sweep restarts cleanly.
